// File: rtl/pc_predict_unit.sv
// Fetch PC register with a direct-mapped BTB (2-bit counters) and execute-stage
// branch resolution that raises a same-cycle flush/redirect on mispredict.
module pc_predict_unit #(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_PC    = '0,
   parameter int              BTB_ENTRIES = 16,
   parameter bit              BTB_EN      = 1'b1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            stall_i,
   output logic [XLEN-1:0] fetch_pc_o,
   output logic            pred_taken_o,
   output logic [XLEN-1:0] pred_target_o,
   input  logic            ex_valid_i,
   input  logic [XLEN-1:0] ex_pc_i,
   input  logic [XLEN-1:0] ex_imm_i,
   input  logic [XLEN-1:0] ex_rs1_i,
   input  logic            ex_is_branch_i,
   input  logic            ex_is_jal_i,
   input  logic            ex_is_jalr_i,
   input  logic            ex_branch_taken_i,
   input  logic            ex_pred_taken_i,
   input  logic [XLEN-1:0] ex_pred_target_i,
   output logic            flush_o,
   output logic [XLEN-1:0] ex_target_o,
   output logic            target_misaligned_o
);

   localparam int IDXW = $clog2(BTB_ENTRIES);
   localparam int TAGW = XLEN - IDXW - 2;

   logic [XLEN-1:0]        fetch_pc_q, fetch_pc_d;
   logic [BTB_ENTRIES-1:0] btb_vld_q;
   logic [TAGW-1:0]        btb_tag_q [BTB_ENTRIES];
   logic [XLEN-1:0]        btb_tgt_q [BTB_ENTRIES];
   logic [1:0]             btb_ctr_q [BTB_ENTRIES];

   logic [IDXW-1:0] f_idx, e_idx;
   logic [TAGW-1:0] f_tag, e_tag;
   logic            f_hit, e_hit;
   logic            pred_taken;
   logic [XLEN-1:0] pred_target;
   logic [XLEN-1:0] jalr_sum, tgt, seq_pc, next_act;
   logic            act_taken, is_ctrl, upd_en, flush;

   assign f_idx = fetch_pc_q[IDXW+1:2];
   assign f_tag = fetch_pc_q[XLEN-1:IDXW+2];
   assign f_hit = btb_vld_q[f_idx] && (btb_tag_q[f_idx] == f_tag);

   assign pred_taken  = BTB_EN && !rst_i && f_hit && btb_ctr_q[f_idx][1];
   assign pred_target = pred_taken ? btb_tgt_q[f_idx] : '0;

   // JALR clears bit 0 of the computed address; B/J immediates arrive pre-shifted.
   assign jalr_sum  = ex_rs1_i + ex_imm_i;
   assign tgt       = ex_is_jalr_i ? {jalr_sum[XLEN-1:1], 1'b0} : (ex_pc_i + ex_imm_i);
   assign seq_pc    = ex_pc_i + XLEN'(4);
   assign act_taken = ex_is_jal_i || ex_is_jalr_i || (ex_is_branch_i && ex_branch_taken_i);
   assign next_act  = act_taken ? tgt : seq_pc;
   assign is_ctrl   = ex_is_branch_i || ex_is_jal_i || ex_is_jalr_i;

   assign flush = ex_valid_i && !rst_i &&
                  ((act_taken != ex_pred_taken_i) || (act_taken && (tgt != ex_pred_target_i)));

   assign e_idx  = ex_pc_i[IDXW+1:2];
   assign e_tag  = ex_pc_i[XLEN-1:IDXW+2];
   assign e_hit  = btb_vld_q[e_idx] && (btb_tag_q[e_idx] == e_tag);
   assign upd_en = BTB_EN && ex_valid_i && is_ctrl;

   always_comb begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (flush)
         fetch_pc_d = next_act;
      else if (stall_i)
         fetch_pc_d = fetch_pc_q;
      else if (pred_taken)
         fetch_pc_d = pred_target;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         fetch_pc_q <= RESET_PC;
      else
         fetch_pc_q <= fetch_pc_d;
   end

   // Writes land at the edge, so a same-cycle lookup still sees the old entry.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         btb_vld_q <= '0;
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            btb_tag_q[i] <= '0;
            btb_tgt_q[i] <= '0;
            btb_ctr_q[i] <= 2'b00;
         end
      end else if (upd_en) begin
         if (e_hit) begin
            if (act_taken) begin
               btb_tgt_q[e_idx] <= tgt;
               if (btb_ctr_q[e_idx] != 2'b11)
                  btb_ctr_q[e_idx] <= btb_ctr_q[e_idx] + 2'd1;
            end else if (btb_ctr_q[e_idx] != 2'b00) begin
               btb_ctr_q[e_idx] <= btb_ctr_q[e_idx] - 2'd1;
            end
         end else if (act_taken) begin
            btb_vld_q[e_idx] <= 1'b1;
            btb_tag_q[e_idx] <= e_tag;
            btb_tgt_q[e_idx] <= tgt;
            btb_ctr_q[e_idx] <= (ex_is_jal_i || ex_is_jalr_i) ? 2'b11 : 2'b10;
         end
      end
   end

   assign fetch_pc_o          = fetch_pc_q;
   assign pred_taken_o        = pred_taken;
   assign pred_target_o       = pred_target;
   assign flush_o             = flush;
   assign ex_target_o         = tgt;
   assign target_misaligned_o = ex_valid_i && act_taken && (tgt[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_predict_unit.sv
// Self-checking bench for pc_predict_unit: directed scenarios plus randomized
// traffic compared against a behavioural model of the PC and BTB.
module tb_pc_predict_unit;

   localparam logic [31:0] RPC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst, stall;
   logic [31:0] fetch_pc, pred_target, ex_pc, ex_imm, ex_rs1, ex_pred_target, ex_target;
   logic        pred_taken, ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
   logic        ex_branch_taken, ex_pred_taken, flush, target_misaligned;

   int n_tests = 0;
   int n_fail  = 0;

   bit          m_vld [16];
   logic [31:0] m_tag [16];
   logic [31:0] m_tgt [16];
   int          m_ctr [16];
   logic [31:0] m_pc;

   always #5 clk = ~clk;

   pc_predict_unit #(
      .XLEN(32), .RESET_PC(RPC), .BTB_ENTRIES(16), .BTB_EN(1'b1)
   ) dut (
      .clk_i(clk), .rst_i(rst), .stall_i(stall),
      .fetch_pc_o(fetch_pc), .pred_taken_o(pred_taken), .pred_target_o(pred_target),
      .ex_valid_i(ex_valid), .ex_pc_i(ex_pc), .ex_imm_i(ex_imm), .ex_rs1_i(ex_rs1),
      .ex_is_branch_i(ex_is_branch), .ex_is_jal_i(ex_is_jal), .ex_is_jalr_i(ex_is_jalr),
      .ex_branch_taken_i(ex_branch_taken), .ex_pred_taken_i(ex_pred_taken),
      .ex_pred_target_i(ex_pred_target), .flush_o(flush), .ex_target_o(ex_target),
      .target_misaligned_o(target_misaligned)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not finish in time, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   function automatic void m_reset();
      m_pc = RPC;
      for (int i = 0; i < 16; i++) begin
         m_vld[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 0;
      end
   endfunction

   function automatic int slot(input logic [31:0] a);
      return int'((a >> 2) & 32'hF);
   endfunction

   function automatic logic [31:0] m_target();
      return ex_is_jalr ? ((ex_rs1 + ex_imm) & 32'hFFFF_FFFE) : (ex_pc + ex_imm);
   endfunction

   function automatic bit m_act();
      return ex_is_jal || ex_is_jalr || (ex_is_branch && ex_branch_taken);
   endfunction

   function automatic bit m_flush();
      if (!ex_valid || rst) return 1'b0;
      return (m_act() != ex_pred_taken) || (m_act() && m_target() != ex_pred_target);
   endfunction

   function automatic bit m_pred();
      int i = slot(m_pc);
      return !rst && m_vld[i] && (m_tag[i] == (m_pc >> 6)) && (m_ctr[i] >= 2);
   endfunction

   function automatic logic [31:0] m_ptgt();
      return m_pred() ? m_tgt[slot(m_pc)] : 32'h0;
   endfunction

   task automatic tick();
      logic [31:0] npc, t;
      bit act;
      int i;
      t   = m_target();
      act = m_act();
      i   = slot(ex_pc);
      if (m_flush())     npc = act ? t : ex_pc + 32'd4;
      else if (stall)    npc = m_pc;
      else if (m_pred()) npc = m_ptgt();
      else               npc = m_pc + 32'd4;
      if (ex_valid && !rst && (ex_is_branch || ex_is_jal || ex_is_jalr)) begin
         if (m_vld[i] && m_tag[i] == (ex_pc >> 6)) begin
            if (act) begin
               m_tgt[i] = t;
               m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
            end else begin
               m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
         end else if (act) begin
            m_vld[i] = 1'b1;
            m_tag[i] = ex_pc >> 6;
            m_tgt[i] = t;
            m_ctr[i] = (ex_is_jal || ex_is_jalr) ? 3 : 2;
         end
      end
      @(posedge clk);
      if (rst) m_reset();
      else     m_pc = npc;
      #1;
   endtask

   task automatic idle();
      ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
      ex_branch_taken = 0; ex_pred_taken = 0; ex_pred_target = 0;
      ex_pc = 0; ex_imm = 0; ex_rs1 = 0;
   endtask

   // A predicted-taken non-control instruction forces a redirect to its pc+4
   // without touching the BTB, which makes it a clean way to steer fetch.
   task automatic redirect_to(input logic [31:0] a);
      idle();
      stall = 0; ex_valid = 1; ex_pc = a - 32'd4; ex_pred_taken = 1;
      #1;
      tick();
      idle();
      #1;
   endtask

   task automatic exec(input logic [31:0] pc, input logic [31:0] imm, input bit br,
                       input bit jal, input bit jalr, input bit tk, input bit pt,
                       input logic [31:0] ptgt);
      idle();
      ex_valid = 1; ex_pc = pc; ex_imm = imm; ex_is_branch = br; ex_is_jal = jal;
      ex_is_jalr = jalr; ex_branch_taken = tk; ex_pred_taken = pt; ex_pred_target = ptgt;
      #1;
   endtask

   task automatic test_reset();
      rst = 0;
      #1;
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (fetch_pc !== RPC + 32'(4 * i) || pred_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_seq[%0d]: got pc=%h pt=%b, required pc=%h pt=0", i, fetch_pc, pred_taken, RPC + 32'(4 * i));
         end
         if (i < 3) tick();
      end
      stall = 1;
      tick();
      n_tests++;
      if (fetch_pc !== 32'h10C) begin
         n_fail++; $display("FAIL stall_hold: got %h, required 0000010c", fetch_pc);
      end
      stall = 0;
   endtask

   task automatic test_jal();
      exec(32'h200, 32'h40, 0, 1, 0, 0, 0, 32'h0);
      stall = 1;
      n_tests++;
      if (flush !== 1'b1 || ex_target !== 32'h240) begin
         n_fail++; $display("FAIL jal_resolve: got flush=%b tgt=%h, required 1 00000240", flush, ex_target);
      end
      tick();
      n_tests++;
      if (fetch_pc !== 32'h240) begin
         n_fail++; $display("FAIL jal_redirect_over_stall: got %h, required 00000240", fetch_pc);
      end
      stall = 0;
      redirect_to(32'h200);
      n_tests++;
      if (pred_taken !== 1'b1 || pred_target !== 32'h240) begin
         n_fail++; $display("FAIL jal_predict: got pt=%b tgt=%h, required 1 00000240", pred_taken, pred_target);
      end
      tick();
      n_tests++;
      if (fetch_pc !== 32'h240) begin
         n_fail++; $display("FAIL jal_follow_pred: got %h, required 00000240", fetch_pc);
      end
   endtask

   task automatic test_jalr_misalign();
      exec(32'h500, 32'h10, 0, 0, 1, 0, 0, 32'h0);
      ex_rs1 = 32'h1001;
      #1;
      n_tests++;
      if (ex_target !== 32'h1010 || target_misaligned !== 1'b0 || flush !== 1'b1) begin
         n_fail++; $display("FAIL jalr_target: got tgt=%h mis=%b fl=%b, required 00001010 0 1", ex_target, target_misaligned, flush);
      end
      tick();
      exec(32'h300, 32'h6, 1, 0, 0, 1, 0, 32'h0);
      n_tests++;
      if (ex_target !== 32'h306 || target_misaligned !== 1'b1 || flush !== 1'b1) begin
         n_fail++; $display("FAIL br_misaligned: got tgt=%h mis=%b fl=%b, required 00000306 1 1", ex_target, target_misaligned, flush);
      end
      tick();
      n_tests++;
      if (fetch_pc !== 32'h306) begin
         n_fail++; $display("FAIL misaligned_redirect: got %h, required 00000306", fetch_pc);
      end
      idle();
   endtask

   task automatic test_counter();
      exec(32'h400, 32'h20, 1, 0, 0, 1, 0, 32'h0);
      tick();
      redirect_to(32'h400);
      n_tests++;
      if (pred_taken !== 1'b1 || pred_target !== 32'h420) begin
         n_fail++; $display("FAIL ctr_alloc_10: got pt=%b tgt=%h, required 1 00000420", pred_taken, pred_target);
      end
      exec(32'h400, 32'h20, 1, 0, 0, 1, 1, 32'h420);
      n_tests++;
      if (flush !== 1'b0) begin
         n_fail++; $display("FAIL ctr_correct_pred: got flush=%b, required 0", flush);
      end
      tick();
      exec(32'h400, 32'h20, 1, 0, 0, 0, 1, 32'h420);
      tick();
      redirect_to(32'h400);
      n_tests++;
      if (pred_taken !== 1'b1) begin
         n_fail++; $display("FAIL ctr_11_to_10: got pt=%b, required 1", pred_taken);
      end
      exec(32'h400, 32'h20, 1, 0, 0, 0, 1, 32'h420);
      n_tests++;
      if (flush !== 1'b1) begin
         n_fail++; $display("FAIL ctr_nt_flush: got flush=%b, required 1", flush);
      end
      tick();
      n_tests++;
      if (fetch_pc !== 32'h404) begin
         n_fail++; $display("FAIL ctr_nt_redirect: got %h, required 00000404", fetch_pc);
      end
      redirect_to(32'h400);
      n_tests++;
      if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin
         n_fail++; $display("FAIL ctr_01_no_pred: got pt=%b tgt=%h, required 0 00000000", pred_taken, pred_target);
      end
   endtask

   task automatic test_evict();
      exec(32'h400, 32'h20, 1, 0, 0, 1, 0, 32'h0);
      tick();
      exec(32'h440, 32'h20, 1, 0, 0, 1, 0, 32'h0);
      tick();
      redirect_to(32'h400);
      n_tests++;
      if (pred_taken !== 1'b0) begin
         n_fail++; $display("FAIL evict_old_miss: got pt=%b, required 0", pred_taken);
      end
      redirect_to(32'h440);
      n_tests++;
      if (pred_taken !== 1'b1 || pred_target !== 32'h460) begin
         n_fail++; $display("FAIL evict_new_hit: got pt=%b tgt=%h, required 1 00000460", pred_taken, pred_target);
      end
   endtask

   task automatic test_wrap();
      redirect_to(32'hFFFF_FFFC);
      tick();
      n_tests++;
      if (fetch_pc !== 32'h0) begin
         n_fail++; $display("FAIL pc_wrap: got %h, required 00000000", fetch_pc);
      end
   endtask

   task automatic test_reset_mid_flush();
      exec(32'h600, 32'h80, 0, 1, 0, 0, 0, 32'h0);
      n_tests++;
      if (flush !== 1'b1) begin
         n_fail++; $display("FAIL pre_reset_flush: got %b, required 1", flush);
      end
      rst = 1;
      m_reset();
      #1;
      n_tests++;
      if (flush !== 1'b0 || fetch_pc !== RPC || pred_taken !== 1'b0 || pred_target !== 32'h0) begin
         n_fail++; $display("FAIL async_reset: got fl=%b pc=%h pt=%b ptg=%h, required 0 %h 0 0", flush, fetch_pc, pred_taken, pred_target, RPC);
      end
      tick();
      rst = 0;
      idle();
      #1;
      n_tests++;
      if (fetch_pc !== RPC) begin
         n_fail++; $display("FAIL first_fetch_after_reset: got %h, required %h", fetch_pc, RPC);
      end
      redirect_to(32'h600);
      n_tests++;
      if (pred_taken !== 1'b0) begin
         n_fail++; $display("FAIL no_write_in_reset: got pt=%b, required 0", pred_taken);
      end
      redirect_to(32'h440);
      n_tests++;
      if (pred_taken !== 1'b0) begin
         n_fail++; $display("FAIL btb_cleared: got pt=%b, required 0", pred_taken);
      end
   endtask

   task automatic test_random();
      logic [31:0] t;
      for (int n = 0; n < 600; n++) begin
         int kind;
         idle();
         kind  = int'($urandom_range(0, 4));
         stall = ($urandom_range(0, 3) == 0);
         ex_valid = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) == 1) ex_pc = m_pc;
         else ex_pc = ($urandom_range(0, 1) ? 32'h8000_0000 : 32'h0) |
                      (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
         ex_imm = 32'($urandom_range(0, 255)) << 1;
         if ($urandom_range(0, 1) == 1) ex_imm = -ex_imm;
         ex_rs1 = $urandom;
         ex_is_branch = (kind == 1 || kind == 4);
         ex_is_jal    = (kind == 2);
         ex_is_jalr   = (kind == 3);
         ex_branch_taken = $urandom_range(0, 1) == 1;
         t = m_target();
         ex_pred_taken  = $urandom_range(0, 1) == 1;
         ex_pred_target = ($urandom_range(0, 3) != 0) ? t : $urandom;
         #1;
         n_tests++;
         if (flush !== m_flush() || ex_target !== t ||
             target_misaligned !== (ex_valid && m_act() && t[1:0] != 2'b00)) begin
            n_fail++;
            $display("FAIL rand_resolve[%0d]: got fl=%b tgt=%h mis=%b, required %b %h %b",
                     n, flush, ex_target, target_misaligned, m_flush(), t,
                     ex_valid && m_act() && t[1:0] != 2'b00);
         end
         n_tests++;
         if (fetch_pc !== m_pc || pred_taken !== m_pred() || pred_target !== m_ptgt()) begin
            n_fail++;
            $display("FAIL rand_fetch[%0d]: got pc=%h pt=%b ptg=%h, required %h %b %h",
                     n, fetch_pc, pred_taken, pred_target, m_pc, m_pred(), m_ptgt());
         end
         tick();
      end
      idle();
      stall = 0;
   endtask

   initial begin
      rst = 1; stall = 0;
      idle();
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_jal();
      test_jalr_misalign();
      test_counter();
      test_evict();
      test_wrap();
      test_reset_mid_flush();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
